// File: rtl/rot_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : rot_stream_reader
//  Description : Walks buffer RAM 0..DEPTH-1, ROT-decodes each byte and
//                streams it out over a valid/ready byte interface.
//  Revision    : 1.0  initial release
// ============================================================================
module rot_stream_reader #(
    parameter int ADDR_W = 8,
    parameter int SHIFT  = 13
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready
);

    localparam logic [ADDR_W-1:0] c_LAST_IDX = '1;
    localparam logic [7:0]        c_SHIFT    = 8'(SHIFT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_READ = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_idx;
    logic [7:0]        r_data;

    // Inverse shift within a 26-letter alphabet starting at i_base.
    function automatic logic [7:0] f_unshift(input logic [7:0] c, input logic [7:0] base);
        logic [7:0] w_sub;
        w_sub = c - c_SHIFT;
        if (w_sub < base) begin
            return c + (8'd26 - c_SHIFT);
        end
        return w_sub;
    endfunction

    function automatic logic [7:0] f_decode(input logic [7:0] c);
        if (c >= 8'd97 && c <= 8'd122) begin
            return f_unshift(c, 8'd97);
        end
        if (c >= 8'd65 && c <= 8'd90) begin
            return f_unshift(c, 8'd65);
        end
        return c;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        mem_rd       = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                mem_rd       = 1'b1;
                w_next_state = S_READ;
            end
            S_READ: begin
                w_next_state = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = (r_idx == c_LAST_IDX) ? S_DONE : S_ADDR;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Index and output byte hold their value through EMIT back-pressure.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idx  <= '0;
            r_data <= 8'd0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_idx <= '0;
            end else if (r_state == S_EMIT && out_ready && r_idx != c_LAST_IDX) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == S_READ) begin
                r_data <= f_decode(mem_rdata);
            end
        end
    end

    assign mem_addr = r_idx;
    assign out_data = r_data;

endmodule
`default_nettype wire
